rdi_pm_link_sequencer: RTL and testbench

- Sequences RDI power-management and link-error entry and exit for the PHY-side RDI.
- Owns the start inputs of rdi_timer_controller and consumes its two timeouts.
- Issues PM requests to the sideband and reports the resulting link status on o_pl_state_sts.
- Sits between the adapter-facing RDI state handshake, the sideband message path and rdi_timer_controller.

---
 rtl/rdi_pkg.sv | 24 ++
 rtl/rdi_pm_link_sequencer_if.sv | 14 +
 rtl/rdi_sb_pm_req_if.sv | 32 +++
 rtl/rdi_pm_link_sequencer.sv | 99 +++++++++
 tb/tb_rdi_pm_link_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rdi_pkg.sv
// rdi_pkg: shared RDI encodings, sequencer state enum and timeout constants.
// Status/request encodings are 4 bits; request ACTIVE/L1/L2 share the status codes.
package rdi_pkg;
  localparam int RDI_STS_W = 4;
  localparam logic [3:0] RDI_STS_RESET     = 4'b0000;
  localparam logic [3:0] RDI_STS_ACTIVE    = 4'b0001;
  localparam logic [3:0] RDI_STS_PMNAK     = 4'b0011;
  localparam logic [3:0] RDI_STS_L1        = 4'b0100;
  localparam logic [3:0] RDI_STS_L2        = 4'b1000;
  localparam logic [3:0] RDI_STS_LINKERROR = 4'b1010;
  localparam int RDI_PM_TIMEOUT_CYC        = 200;
  localparam int RDI_LINKERROR_TIMEOUT_CYC = 1600;
  typedef enum logic [2:0] {
    ST_RESET, ST_ACTIVE, ST_PM_REQ, ST_PM_WAIT, ST_PM_L1, ST_PM_L2, ST_PMNAK, ST_LINKERR
  } rdi_state_e;
  // The handshake states PM_REQ/PM_WAIT still report ACTIVE to the adapter.
  function automatic logic [3:0] rdi_sts_of(rdi_state_e s);
    return (s == ST_ACTIVE || s == ST_PM_REQ || s == ST_PM_WAIT) ? RDI_STS_ACTIVE :
           (s == ST_PMNAK)   ? RDI_STS_PMNAK :
           (s == ST_PM_L1)   ? RDI_STS_L1 :
           (s == ST_PM_L2)   ? RDI_STS_L2 :
           (s == ST_LINKERR) ? RDI_STS_LINKERROR : RDI_STS_RESET;
  endfunction
endpackage

// File: rtl/rdi_pm_link_sequencer_if.sv
// rdi_pm_link_sequencer_if: sideband PM request/response bundle.
// master (sequencer): drives o_sb_pm_req_valid/type, receives ready and the response strobe.
// slave (sideband): the mirror view.
interface rdi_pm_link_sequencer_if;
  logic o_sb_pm_req_valid;
  logic o_sb_pm_req_type;
  logic i_sb_req_ready;
  logic i_sb_pm_rsp_valid;
  logic i_sb_pm_rsp_ack;
  modport master (output o_sb_pm_req_valid, o_sb_pm_req_type,
                  input  i_sb_req_ready, i_sb_pm_rsp_valid, i_sb_pm_rsp_ack);
  modport slave  (input  o_sb_pm_req_valid, o_sb_pm_req_type,
                  output i_sb_req_ready, i_sb_pm_rsp_valid, i_sb_pm_rsp_ack);
endinterface

// File: rtl/rdi_sb_pm_req_if.sv
// rdi_sb_pm_req_if: registered valid/ready PM request toward the sideband.
// Ports: lclk, sys_rst (async active-low); req (valid next cycle), load/type_in (latch target);
// ready from sideband; valid/req_type registered outputs; accept = handshake completes this cycle.
module rdi_sb_pm_req_if (
  input  logic lclk,
  input  logic sys_rst,
  input  logic req,
  input  logic load,
  input  logic type_in,
  input  logic ready,
  output logic valid,
  output logic req_type,
  output logic accept
);
  logic valid_q, valid_d, type_q, type_d;
  always_comb begin
    valid_d = req;
    type_d  = load ? type_in : type_q;
  end
  always_ff @(posedge lclk or negedge sys_rst) begin
    if (!sys_rst) begin
      valid_q <= 1'b0;
      type_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      type_q  <= type_d;
    end
  end
  assign valid    = valid_q;
  assign req_type = type_q;
  assign accept   = valid_q & ready;
endmodule

// File: rtl/rdi_pm_link_sequencer.sv
// rdi_pm_link_sequencer: RDI PM / link-error entry and exit sequencing for the PHY-side RDI.
// Ports: lclk, sys_rst (async active-low); i_lp_state_req/i_lp_linkerror from the adapter;
// sb (sideband PM request/response, master view); o_pm_timer_start/i_pm_timeout and
// o_linkerror_timer_start/i_linkerror_timeout toward rdi_timer_controller; o_pl_state_sts status.
// Optional macro RDI_PM_RETRY_EN: PM timeouts re-send the request up to PM_MAX_RETRY times.
module rdi_pm_link_sequencer
  import rdi_pkg::*;
#(
  parameter int STS_W        = RDI_STS_W,
  parameter int PM_MAX_RETRY = 2
) (
  input  logic             lclk,
  input  logic             sys_rst,
  input  logic [STS_W-1:0] i_lp_state_req,
  input  logic             i_lp_linkerror,
  rdi_pm_link_sequencer_if.master sb,
  output logic             o_pm_timer_start,
  input  logic             i_pm_timeout,
  output logic             o_linkerror_timer_start,
  input  logic             i_linkerror_timeout,
  output logic [STS_W-1:0] o_pl_state_sts
);
  rdi_state_e state_q, state_d;
  logic flag_q, flag_d, pm_timer_q, pm_timer_d, le_timer_q, le_timer_d;
  logic [STS_W-1:0] sts_q, sts_d;
  logic load, req_valid, req_type, accept, retry_ok, req_act, req_pm;
  assign req_act = i_lp_state_req == STS_W'(RDI_STS_ACTIVE);
  assign req_pm  = i_lp_state_req == STS_W'(RDI_STS_L1) || i_lp_state_req == STS_W'(RDI_STS_L2);
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (i_lp_linkerror) state_d = ST_LINKERR;
    else case (state_q)
      ST_RESET:   if (req_act) state_d = ST_ACTIVE;
      ST_ACTIVE:  if (req_pm) begin state_d = ST_PM_REQ; load = 1'b1; end
      ST_PM_REQ:  if (accept) state_d = ST_PM_WAIT;
      // A response outranks a same-cycle timeout.
      ST_PM_WAIT: if (sb.i_sb_pm_rsp_valid)
                    state_d = sb.i_sb_pm_rsp_ack ? (req_type ? ST_PM_L2 : ST_PM_L1) : ST_PMNAK;
                  else if (i_pm_timeout) state_d = retry_ok ? ST_PM_REQ : ST_PMNAK;
      ST_PM_L1:   if (req_act) state_d = ST_ACTIVE;
      ST_PM_L2:   if (req_act) state_d = ST_RESET;
      ST_PMNAK:   if (req_act) state_d = ST_ACTIVE;
                  else if (req_pm) begin state_d = ST_PM_REQ; load = 1'b1; end
      ST_LINKERR: if (flag_q) state_d = ST_RESET;
      default:    state_d = ST_RESET;
    endcase
    // Sticky: minimum residency is met once the timer has fired at least once.
    flag_d     = state_d == ST_LINKERR && (flag_q || (state_q == ST_LINKERR && i_linkerror_timeout));
    pm_timer_d = state_d == ST_PM_WAIT;
    le_timer_d = state_d == ST_LINKERR;
    sts_d      = STS_W'(rdi_sts_of(state_d));
  end
  always_ff @(posedge lclk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q    <= ST_RESET;
      flag_q     <= 1'b0;
      pm_timer_q <= 1'b0;
      le_timer_q <= 1'b0;
      sts_q      <= '0;
    end else begin
      state_q    <= state_d;
      flag_q     <= flag_d;
      pm_timer_q <= pm_timer_d;
      le_timer_q <= le_timer_d;
      sts_q      <= sts_d;
    end
  end
`ifdef RDI_PM_RETRY_EN
  localparam int RETRY_W = $clog2(PM_MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_q, retry_d;
  assign retry_ok = retry_q < RETRY_W'(PM_MAX_RETRY);
  // PMNAK and PM_REQ keep the count, so a fresh request after PMNAK inherits it.
  always_comb retry_d = (state_d inside {ST_ACTIVE, ST_PM_L1, ST_PM_L2, ST_RESET, ST_LINKERR}) ? '0 :
                        (state_q == ST_PM_WAIT && state_d == ST_PM_REQ) ? retry_q + 1'b1 : retry_q;
  always_ff @(posedge lclk or negedge sys_rst) begin
    if (!sys_rst) retry_q <= '0;
    else retry_q <= retry_d;
  end
`else
  assign retry_ok = 1'b0;
`endif
  rdi_sb_pm_req_if u_req (
    .lclk     (lclk),
    .sys_rst  (sys_rst),
    .req      (state_d == ST_PM_REQ),
    .load     (load),
    .type_in  (i_lp_state_req == STS_W'(RDI_STS_L2)),
    .ready    (sb.i_sb_req_ready),
    .valid    (req_valid),
    .req_type (req_type),
    .accept   (accept)
  );
  assign sb.o_sb_pm_req_valid    = req_valid;
  assign sb.o_sb_pm_req_type     = req_type;
  assign o_pm_timer_start        = pm_timer_q;
  assign o_linkerror_timer_start = le_timer_q;
  assign o_pl_state_sts          = sts_q;
endmodule

// File: tb/tb_rdi_pm_link_sequencer.sv
// tb_rdi_pm_link_sequencer: randomized scenarios against a spec-level reference model.
module tb_rdi_pm_link_sequencer;
  import rdi_pkg::*;
  localparam int MAXR = 2;
`ifdef RDI_PM_RETRY_EN
  localparam int RETRY_EN = 1;
`else
  localparam int RETRY_EN = 0;
`endif
  localparam int S_RST = 0, S_ACT = 1, S_REQ = 2, S_WAIT = 3, S_L1 = 4, S_L2 = 5, S_NAK = 6, S_LE = 7;
  logic lclk = 1'b0, sys_rst = 1'b0;
  logic [3:0] req = 4'b0;
  logic le = 1'b0, rdy = 1'b0, rv = 1'b0, ack = 1'b0, pm_to = 1'b0, le_to = 1'b0;
  logic pm_start, le_start;
  logic [3:0] sts;
  logic [7:0] obs;
  int ms, mretry, pm_cnt, le_cnt, n_cmp, n_bad;
  bit mtype, mflag, force_to;
  rdi_pm_link_sequencer_if sb();
  assign sb.i_sb_req_ready    = rdy;
  assign sb.i_sb_pm_rsp_valid = rv;
  assign sb.i_sb_pm_rsp_ack   = ack;
  assign obs = {sts, sb.o_sb_pm_req_valid, sb.o_sb_pm_req_type, pm_start, le_start};
  rdi_pm_link_sequencer #(.STS_W(4), .PM_MAX_RETRY(MAXR)) dut (
    .lclk(lclk), .sys_rst(sys_rst), .i_lp_state_req(req), .i_lp_linkerror(le), .sb(sb),
    .o_pm_timer_start(pm_start), .i_pm_timeout(pm_to),
    .o_linkerror_timer_start(le_start), .i_linkerror_timeout(le_to), .o_pl_state_sts(sts));
  always #5 lclk = ~lclk;
  function automatic logic [7:0] exp_vec();
    logic [3:0] s;
    s = (ms == S_ACT || ms == S_REQ || ms == S_WAIT) ? 4'b0001 : ms == S_NAK ? 4'b0011 :
        ms == S_L1 ? 4'b0100 : ms == S_L2 ? 4'b1000 : ms == S_LE ? 4'b1010 : 4'b0000;
    return {s, ms == S_REQ, mtype, ms == S_WAIT, ms == S_LE};
  endfunction
  function automatic void model_reset();
    ms = S_RST; mtype = 0; mflag = 0; mretry = 0; pm_cnt = 0; le_cnt = 0;
  endfunction
  function automatic void model_next();
    int n;
    bit pmr;
    n = ms;
    pmr = req == 4'b0100 || req == 4'b1000;
    if (le) n = S_LE;
    else if (ms == S_RST && req == 4'b0001) n = S_ACT;
    else if ((ms == S_ACT || ms == S_NAK) && pmr) begin n = S_REQ; mtype = req[3]; end
    else if (ms == S_NAK && req == 4'b0001) n = S_ACT;
    else if (ms == S_REQ && rdy) n = S_WAIT;
    else if (ms == S_WAIT && rv) n = ack ? (mtype ? S_L2 : S_L1) : S_NAK;
    else if (ms == S_WAIT && pm_to) begin
      if (RETRY_EN != 0 && mretry < MAXR) begin mretry++; n = S_REQ; end
      else n = S_NAK;
    end
    else if (ms == S_L1 && req == 4'b0001) n = S_ACT;
    else if (ms == S_L2 && req == 4'b0001) n = S_RST;
    else if (ms == S_LE && mflag) n = S_RST;
    mflag = n == S_LE && (mflag || (ms == S_LE && le_to));
    if (n == S_ACT || n == S_L1 || n == S_L2 || n == S_RST || n == S_LE) mretry = 0;
    ms = n;
  endfunction
  // Stands in for rdi_timer_controller: timeouts derive from the model's expected timer starts.
  task automatic step();
    pm_to = force_to | (pm_cnt == RDI_PM_TIMEOUT_CYC);
    le_to = le_cnt >= RDI_LINKERROR_TIMEOUT_CYC;
    model_next();
    @(posedge lclk);
    #1;
    pm_cnt = ms == S_WAIT ? pm_cnt + 1 : 0;
    le_cnt = ms == S_LE ? le_cnt + 1 : 0;
    force_to = 0;
    rv = 0;
  endtask
  task automatic do_reset();
    sys_rst = 0; le = 0; rdy = 0; rv = 0; ack = 0; req = 0; force_to = 0;
    model_reset();
    @(posedge lclk);
    #1;
    sys_rst = 1;
  endtask
  task automatic go_active();
    do_reset();
    req = 4'b0001; step();
    req = 4'b0000; step();
  endtask
  task automatic go_wait(input bit t);
    go_active();
    req = t ? 4'b1000 : 4'b0100; step();
    req = 4'b0000; rdy = 1; step();
    rdy = 0;
  endtask
  task automatic test_reset();
    sys_rst = 0; req = 4'b0001;
    model_reset();
    #1;
    n_cmp++; if (obs !== 8'h00) begin n_bad++; $display("FAIL reset_async: obs=%h exp=00", obs); end
    @(posedge lclk); #1;
    n_cmp++; if (obs !== 8'h00) begin n_bad++; $display("FAIL reset_held: obs=%h exp=00", obs); end
    req = 4'b0100; sys_rst = 1; step();
    n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_bad_req: obs=%h exp=%h", obs, exp_vec()); end
    req = 4'b0001; step();
    n_cmp++; if (sts !== 4'b0001) begin n_bad++; $display("FAIL reset_to_active: sts=%b exp=0001", sts); end
  endtask
  task automatic test_l1_entry();
    int d;
    go_active();
    n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL l1_active: obs=%h exp=%h", obs, exp_vec()); end
    req = 4'b0100; step();
    n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL l1_req: obs=%h exp=%h", obs, exp_vec()); end
    req = 4'b0000;
    d = $urandom_range(0, 3);
    for (int i = 0; i < d; i++) begin
      step();
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL l1_stall: obs=%h exp=%h", obs, exp_vec()); end
    end
    rdy = 1; step(); rdy = 0;
    n_cmp++; if (pm_start !== 1'b1 || sb.o_sb_pm_req_valid !== 1'b0) begin n_bad++; $display("FAIL l1_wait: pm_start=%b valid=%b exp=1 0", pm_start, sb.o_sb_pm_req_valid); end
    d = $urandom_range(0, 5);
    for (int i = 0; i < d; i++) begin
      step();
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL l1_waiting: obs=%h exp=%h", obs, exp_vec()); end
    end
    rv = 1; ack = 1; step();
    n_cmp++; if (sts !== 4'b0100 || pm_start !== 1'b0) begin n_bad++; $display("FAIL l1_ack: sts=%b pm_start=%b exp=0100 0", sts, pm_start); end
    rv = 1; ack = 0; step();
    n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL l1_stray_rsp: obs=%h exp=%h", obs, exp_vec()); end
    req = 4'b0001; step();
    n_cmp++; if (sts !== 4'b0001) begin n_bad++; $display("FAIL l1_exit: sts=%b exp=0001", sts); end
  endtask
  task automatic test_ready_stall();
    go_active();
    req = 4'b1000; step(); req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (obs[3:0] !== 4'b1100 || obs !== exp_vec()) begin n_bad++; $display("FAIL stall_hold: obs=%h exp=%h", obs, exp_vec()); end
    end
    rdy = 1; step(); rdy = 0;
    n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL stall_accept: obs=%h exp=%h", obs, exp_vec()); end
    rv = 1; ack = 0; step();
    n_cmp++; if (sts !== 4'b0011 || obs !== exp_vec()) begin n_bad++; $display("FAIL stall_nak: obs=%h exp=%h", obs, exp_vec()); end
    req = 4'b0001; step();
    n_cmp++; if (sts !== 4'b0001) begin n_bad++; $display("FAIL nak_to_active: sts=%b exp=0001", sts); end
  endtask
  task automatic test_timeout();
    int rises, n;
    bit prev;
    go_active();
    req = 4'b0100; step(); req = 4'b0000; rdy = 1;
    prev = 1; rises = 0; n = 0;
    while (ms != S_NAK && n < 2000) begin
      step(); n++;
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL timeout_seq: obs=%h exp=%h", obs, exp_vec()); end
      if (sb.o_sb_pm_req_valid && !prev) rises++;
      prev = sb.o_sb_pm_req_valid;
    end
    rdy = 0;
    n_cmp++; if (sts !== 4'b0011) begin n_bad++; $display("FAIL timeout_nak: sts=%b exp=0011 (steps=%0d)", sts, n); end
    n_cmp++; if (rises != RETRY_EN * MAXR) begin n_bad++; $display("FAIL timeout_retries: got=%0d exp=%0d", rises, RETRY_EN * MAXR); end
  endtask
  task automatic test_rsp_vs_timeout();
    bit t;
    t = 1'($urandom_range(0, 1));
    go_wait(t);
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) step();
    rv = 1; ack = 1; force_to = 1; step();
    n_cmp++; if (sts !== (t ? 4'b1000 : 4'b0100) || obs !== exp_vec()) begin n_bad++; $display("FAIL rsp_beats_to: obs=%h exp=%h", obs, exp_vec()); end
  endtask
  task automatic test_linkerror_pulse();
    int n;
    go_wait(1'($urandom_range(0, 1)));
    le = 1; rv = 1; ack = 1; step(); le = 0;
    n_cmp++; if (sts !== 4'b1010 || pm_start !== 1'b0 || le_start !== 1'b1) begin n_bad++; $display("FAIL le_entry: sts=%b pm=%b le=%b exp=1010 0 1", sts, pm_start, le_start); end
    n = 1;
    while (ms != S_RST && n < 2000) begin
      step(); n++;
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL le_resid: obs=%h exp=%h", obs, exp_vec()); end
    end
    n_cmp++; if (sts !== 4'b0000 || n <= RDI_LINKERROR_TIMEOUT_CYC) begin n_bad++; $display("FAIL le_exit: sts=%b cycles=%0d exp=0000 >%0d", sts, n, RDI_LINKERROR_TIMEOUT_CYC); end
  endtask
  task automatic test_linkerror_held();
    go_active();
    le = 1;
    for (int i = 0; i < 1700; i++) begin
      step();
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL le_held: obs=%h exp=%h", obs, exp_vec()); end
    end
    n_cmp++; if (sts !== 4'b1010) begin n_bad++; $display("FAIL le_held_sts: sts=%b exp=1010", sts); end
    le = 0; step();
    n_cmp++; if (sts !== 4'b0000 || le_start !== 1'b0) begin n_bad++; $display("FAIL le_release: sts=%b le_start=%b exp=0000 0", sts, le_start); end
  endtask
  task automatic test_l2_exit();
    go_wait(1);
    rv = 1; ack = 1; step();
    n_cmp++; if (sts !== 4'b1000) begin n_bad++; $display("FAIL l2_entry: sts=%b exp=1000", sts); end
    req = 4'b0001; step(); req = 4'b0000;
    n_cmp++; if (sts !== 4'b0000) begin n_bad++; $display("FAIL l2_to_reset: sts=%b exp=0000", sts); end
    step();
    n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL l2_reset_hold: obs=%h exp=%h", obs, exp_vec()); end
    req = 4'b0001; step();
    n_cmp++; if (sts !== 4'b0001) begin n_bad++; $display("FAIL l2_reactivate: sts=%b exp=0001", sts); end
  endtask
  task automatic test_reset_mid();
    go_active();
    req = 4'b1000; step();
    #3 sys_rst = 0;
    #1;
    model_reset();
    n_cmp++; if (obs !== 8'h00) begin n_bad++; $display("FAIL reset_mid: obs=%h exp=00", obs); end
    @(posedge lclk); #1;
    sys_rst = 1; rdy = 1; step(); rdy = 0;
    n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_mid_after: obs=%h exp=%h", obs, exp_vec()); end
  endtask
  task automatic test_random();
    logic [3:0] reqs [6];
    reqs = '{4'b0000, 4'b0001, 4'b0100, 4'b1000, 4'b0101, 4'b1111};
    do_reset();
    for (int i = 0; i < 800; i++) begin
      req = reqs[$urandom_range(0, 5)];
      rdy = 1'($urandom_range(0, 1));
      rv = $urandom_range(0, 5) == 0;
      ack = 1'($urandom_range(0, 1));
      le = ms != S_LE && $urandom_range(0, 399) == 0;
      step();
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL random[%0d]: obs=%h exp=%h", i, obs, exp_vec()); end
    end
    le = 0;
  endtask
  initial begin
    test_reset();
    test_l1_entry();
    test_l1_entry();
    test_ready_stall();
    test_timeout();
    test_rsp_vs_timeout();
    test_rsp_vs_timeout();
    test_linkerror_pulse();
    test_linkerror_held();
    test_l2_exit();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
